pad_window_gen: RTL and testbench

Streaming zero-padding and 3x3 window generator for the CNN front end. It accepts a raster-order, multi-channel pixel stream for one IMG_H x IMG_W frame and conceptually pads it with one zero pixel on all four sides. It emits one 3x3 window per output pixel, IMG_H*IMG_W windows per frame, in raster order. It sits between the image DMA/input stage and the convolution PE array, and replaces whole-row padded register dumps with a valid/ready window stream that supports backpressure.

---
 rtl/padding_pkg.sv | 10 +
 rtl/line_buffer.sv | 24 ++
 rtl/pad_window_gen.sv | 114 +++++++++++
 tb/tb_pad_window_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/padding_pkg.sv
// padding_pkg: shared FSM states, padding geometry and tap indexing for the window generator
package padding_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  localparam int PAD = 1;
  localparam int K = 3;
  localparam int TAPS = K * K;
  function automatic int tap_idx(input int i, input int j);
    return K * i + j;
  endfunction
endpackage

// File: rtl/line_buffer.sv
// line_buffer: two-row circular store addressed by padded column; a write ages the column by one row
module line_buffer #(
  parameter int DEPTH = 418,
  parameter int W = 24,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  input  logic          wr_en_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  top_o,
  output logic [W-1:0]  mid_o
);
  logic [W-1:0] top_mem [DEPTH];
  logic [W-1:0] mid_mem [DEPTH];
  assign top_o = top_mem[addr_i];
  assign mid_o = mid_mem[addr_i];
  // mid row entry moves up to the top row as the new sample lands in the mid row
  always_ff @(posedge clk)
    if (wr_en_i) begin
      top_mem[addr_i] <= mid_mem[addr_i];
      mid_mem[addr_i] <= din_i;
    end
endmodule

// File: rtl/pad_window_gen.sv
// pad_window_gen: zero-pads a raster pixel stream by one and emits 3x3 windows with valid/ready
module pad_window_gen
  import padding_pkg::*;
#(
  parameter int IMG_W = 416,
  parameter int IMG_H = 416,
  parameter int CH = 3,
  parameter int DATA_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CH*DATA_W-1:0]        in_pixel,
  output logic                        win_valid,
  input  logic                        win_ready,
  output logic [TAPS*CH*DATA_W-1:0]   win_data,
  output logic                        busy,
  output logic                        frame_done
);
  localparam int PW = CH * DATA_W;
  localparam int VCW = $clog2(IMG_W + 2 * PAD);
  localparam int VRW = $clog2(IMG_H + 2 * PAD);
  localparam logic [VCW-1:0] VC_LAST = VCW'(IMG_W + 2 * PAD - 1);
  localparam logic [VRW-1:0] VR_LAST = VRW'(IMG_H + 2 * PAD - 1);
  localparam logic [VCW-1:0] VC_IN_LO = VCW'(PAD);
  localparam logic [VCW-1:0] VC_IN_HI = VCW'(IMG_W);
  localparam logic [VRW-1:0] VR_IN_LO = VRW'(PAD);
  localparam logic [VRW-1:0] VR_IN_HI = VRW'(IMG_H);
  localparam logic [VCW-1:0] VC_WIN = VCW'(K - 1);
  localparam logic [VRW-1:0] VR_WIN = VRW'(K - 1);
  state_e state_q, state_d;
  logic [VCW-1:0] vc_q, vc_d;
  logic [VRW-1:0] vr_q, vr_d;
  logic win_valid_q, win_valid_d, frame_done_q, frame_done_d;
  logic [TAPS*PW-1:0] win_data_q, win_d;
  logic [K-1:0][PW-1:0] c0_q, c1_q, col;
  logic [PW-1:0] sample, lb_top, lb_mid;
  logic interior, room, adv, complete, last;
  assign interior = vr_q >= VR_IN_LO && vr_q <= VR_IN_HI && vc_q >= VC_IN_LO && vc_q <= VC_IN_HI;
  assign room = !win_valid_q || win_ready;
  assign in_ready = state_q == RUN && interior && room;
  assign adv = state_q == RUN && room && (!interior || in_valid);
  assign sample = interior ? in_pixel : '0;
  assign col = {sample, lb_mid, lb_top};
  assign complete = adv && vr_q >= VR_WIN && vc_q >= VC_WIN;
  assign last = vr_q == VR_LAST && vc_q == VC_LAST;
  assign win_valid = win_valid_q;
  assign win_data = win_data_q;
  assign frame_done = frame_done_q;
  assign busy = state_q != IDLE;
  line_buffer #(.DEPTH(IMG_W + 2 * PAD), .W(PW)) u_lb (
    .clk    (clk),
    .addr_i (vc_q),
    .wr_en_i(adv),
    .din_i  (sample),
    .top_o  (lb_top),
    .mid_o  (lb_mid)
  );
  for (genvar i = 0; i < K; i++) begin : g_row
    for (genvar j = 0; j < K; j++) begin : g_col
      assign win_d[tap_idx(i, j)*PW +: PW] = j == 0 ? c0_q[i] : j == 1 ? c1_q[i] : col[i];
    end
  end
  // FSM, raster position counters and output handshake bookkeeping
  always_comb begin
    state_d = state_q;
    vc_d = vc_q;
    vr_d = vr_q;
    frame_done_d = 1'b0;
    win_valid_d = complete || (win_valid_q && !win_ready);
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        vc_d = '0;
        vr_d = '0;
      end
      RUN: if (adv) begin
        vc_d = vc_q == VC_LAST ? '0 : vc_q + 1'b1;
        vr_d = vc_q != VC_LAST ? vr_q : last ? '0 : vr_q + 1'b1;
        state_d = last ? DRAIN : RUN;
      end
      DRAIN: if (win_ready) begin
        state_d = IDLE;
        frame_done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // control state and output register; the window is captured only when it completes
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      vc_q <= '0;
      vr_q <= '0;
      win_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      win_data_q <= '0;
    end else begin
      state_q <= state_d;
      vc_q <= vc_d;
      vr_q <= vr_d;
      win_valid_q <= win_valid_d;
      frame_done_q <= frame_done_d;
      if (complete) win_data_q <= win_d;
    end
  // two previous window columns; pad columns flush them at every row start
  always_ff @(posedge clk)
    if (adv) begin
      c0_q <= c1_q;
      c1_q <= col;
    end
endmodule

// File: tb/tb_pad_window_gen.sv
// tb_pad_window_gen: random and directed frames checked against a padded-grid window model
module tb_pad_window_gen;
  localparam int W = 4, H = 3, CH = 3, DW = 8, PW = CH * DW, WD = 9 * PW, N = W * H;
  logic clk = 0, reset = 1, start = 0, in_valid = 0, win_ready = 0;
  logic [PW-1:0] in_pixel = '0;
  logic in_ready, win_valid, busy, frame_done;
  logic [WD-1:0] win_data;
  logic start1 = 0, in_valid1 = 0, win_ready1 = 0;
  logic [PW-1:0] in_pixel1 = '0;
  logic in_ready1, win_valid1, busy1, frame_done1;
  logic [WD-1:0] win_data1;
  int checks = 0, errors = 0;
  logic [PW-1:0] pix [N];
  logic [WD-1:0] got [N];

  always #5 clk = ~clk;

  pad_window_gen #(.IMG_W(W), .IMG_H(H), .CH(CH), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .busy(busy), .frame_done(frame_done)
  );

  pad_window_gen #(.IMG_W(1), .IMG_H(1), .CH(CH), .DATA_W(DW)) dut_min (
    .clk(clk), .reset(reset), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_pixel(in_pixel1), .win_valid(win_valid1), .win_ready(win_ready1), .win_data(win_data1),
    .busy(busy1), .frame_done(frame_done1)
  );

  task automatic chk(input string tag, input logic [WD-1:0] obs, input logic [WD-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WD-1:0] model_win(input int k);
    logic [WD-1:0] w;
    int r, c, rr, cc;
    w = '0;
    r = k / W;
    c = k % W;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        rr = r + i - 1;
        cc = c + j - 1;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W) w[(3*i+j)*PW +: PW] = pix[rr*W+cc];
      end
    return w;
  endfunction

  task automatic fill_ramp();
    for (int k = 0; k < N; k++) pix[k] = {CH{DW'(k)}};
  endtask

  task automatic fill_rand();
    for (int k = 0; k < N; k++) pix[k] = PW'($urandom);
  endtask

  task automatic run_frame(input bit b2b, input bit gap, input int bp_len, input bit chk_lat, input string tag);
    int bi = 0, wi = 0, cyc = 0, bp = 0, first = 0, busy_cyc = 0;
    bit done = 0, holding = 0;
    logic [WD-1:0] held = '0;
    if (!b2b) @(negedge clk);
    start = 1;
    @(posedge clk);
    while (!done && cyc < 3000) begin
      @(negedge clk);
      start = 0;
      cyc++;
      in_valid = bi < N && (!gap || cyc % 2 == 1);
      in_pixel = in_valid ? pix[bi] : PW'($urandom);
      win_ready = !(wi == 3 && bp < bp_len);
      #1;
      if (busy) busy_cyc++;
      if (win_valid && first == 0) first = cyc;
      if (win_valid && !win_ready) begin
        if (holding) chk({tag, " hold"}, win_data, held);
        chk({tag, " stall in_ready"}, WD'(in_ready), '0);
        holding = 1;
        held = win_data;
        bp++;
      end else holding = 0;
      if (in_valid && in_ready) bi++;
      if (win_valid && win_ready) begin
        if (wi < N) begin
          got[wi] = win_data;
          chk($sformatf("%s win%0d", tag, wi), win_data, model_win(wi));
        end
        wi++;
      end
      if (frame_done) begin
        done = 1;
        chk({tag, " busy at done"}, WD'(busy), '0);
        chk({tag, " beats"}, WD'(bi), WD'(N));
        chk({tag, " windows"}, WD'(wi), WD'(N));
      end
    end
    chk({tag, " done seen"}, WD'(done), WD'(1));
    if (chk_lat) begin
      chk({tag, " first window cycle"}, WD'(first), WD'(2 * (W + 2) + 4));
      chk({tag, " busy cycles"}, WD'(busy_cyc), WD'((H + 2) * (W + 2) + 1));
    end
  endtask

  initial begin
    int rb, rn, m_bi, m_wi, m_fd;
    logic [WD-1:0] e;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", WD'(in_ready), '0);
    chk("reset win_valid", WD'(win_valid), '0);
    chk("reset busy", WD'(busy), '0);
    chk("reset frame_done", WD'(frame_done), '0);
    chk("reset win_data", win_data, '0);
    @(negedge clk);
    reset = 0;

    fill_ramp();
    run_frame(0, 0, 0, 1, "ramp");
    e = '0;
    e[5*PW +: PW] = {CH{8'd1}};
    e[7*PW +: PW] = {CH{8'd4}};
    e[8*PW +: PW] = {CH{8'd5}};
    chk("ramp window0", got[0], e);
    e = '0;
    e[0*PW +: PW] = {CH{8'd6}};
    e[1*PW +: PW] = {CH{8'd7}};
    e[3*PW +: PW] = {CH{8'd10}};
    e[4*PW +: PW] = {CH{8'd11}};
    chk("ramp window11", got[N-1], e);
    repeat (2) begin
      @(negedge clk);
      in_valid = 1;
      in_pixel = PW'($urandom);
      #1;
      chk("idle frame_done", WD'(frame_done), '0);
      chk("idle in_ready", WD'(in_ready), '0);
    end
    in_valid = 0;

    fill_rand();
    run_frame(0, 0, 5, 0, "backpressure");

    fill_ramp();
    run_frame(0, 1, 0, 0, "gaps");

    fill_rand();
    @(negedge clk);
    start = 1;
    @(posedge clk);
    rb = 0;
    rn = 0;
    while (rb < 6 && rn < 200) begin
      @(negedge clk);
      start = 0;
      rn++;
      in_valid = 1;
      in_pixel = pix[rb];
      win_ready = 1;
      #1;
      if (in_ready) rb++;
    end
    chk("pre-reset beats", WD'(rb), WD'(6));
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    chk("midreset in_ready", WD'(in_ready), '0);
    chk("midreset win_valid", WD'(win_valid), '0);
    chk("midreset busy", WD'(busy), '0);
    chk("midreset frame_done", WD'(frame_done), '0);
    chk("midreset win_data", win_data, '0);
    @(negedge clk);
    reset = 0;
    in_valid = 0;
    fill_rand();
    run_frame(0, 0, 0, 1, "after reset");

    fill_rand();
    run_frame(0, 0, 0, 0, "b2b first");
    fill_rand();
    run_frame(1, 0, 0, 1, "b2b second");
    chk("b2b window0 top row", WD'(got[0][3*PW-1:0]), '0);

    e = '0;
    e[4*PW +: PW] = {CH{8'hA5}};
    @(negedge clk);
    start1 = 1;
    @(posedge clk);
    m_bi = 0;
    m_wi = 0;
    m_fd = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      start1 = 0;
      in_valid1 = m_bi < 1;
      in_pixel1 = {CH{8'hA5}};
      win_ready1 = 1;
      #1;
      if (in_valid1 && in_ready1) m_bi++;
      if (win_valid1) begin
        chk("min window", win_data1, e);
        m_wi++;
      end
      if (frame_done1) m_fd++;
    end
    chk("min beats", WD'(m_bi), WD'(1));
    chk("min windows", WD'(m_wi), WD'(1));
    chk("min frame_done", WD'(m_fd), WD'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
